tree_infer_ctrl: RTL

//  Traversal controller for the decision-tree node memory. Latches one 3-feature CAN sample and walks the tree from ROOT_ADDR.
//  - Per node: issues a one-cycle read, waits for the node fields, compares the selected feature against the threshold, then follows the left or right child.
//  - On a leaf, returns the class prediction and the path depth.
//  - Sits between the CAN feature extractor (upstream) and the alert logic (downstream).

---
 rtl/tree_infer_ctrl.sv | 168 ++++++++++++++++
 1 files changed

// File: rtl/tree_infer_ctrl.sv
// Decision-tree traversal controller: latches one 3-feature sample and walks the node memory.
// Define TREE_CTRL_SIGNED_CMP_EN to compare features and thresholds as signed two's-complement.
module tree_infer_ctrl #(
    parameter int unsigned ROOT_ADDR   = 0,
    parameter int unsigned TREE_DEPTH  = 512,
    parameter int unsigned MAX_DEPTH   = 32,
    parameter int unsigned MEM_TIMEOUT = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    // sample input
    input  logic        start,
    output logic        ready,
    input  logic [63:0] feat0,
    input  logic [63:0] feat1,
    input  logic [63:0] feat2,
    // tree node memory
    output logic        mem_rd_en,
    output logic [8:0]  mem_addr,
    input  logic        mem_data_valid,
    input  logic [1:0]  mem_feature_idx,
    input  logic [63:0] mem_threshold,
    input  logic [8:0]  mem_left,
    input  logic [8:0]  mem_right,
    input  logic [1:0]  mem_pred,
    input  logic        mem_is_leaf,
    // result output
    output logic        result_valid,
    input  logic        result_ready,
    output logic [1:0]  result_pred,
    output logic [8:0]  result_depth,
    output logic [1:0]  err_code
);

    localparam logic [8:0]      RootAddr  = 9'(ROOT_ADDR);
    localparam logic [9:0]      AddrLimit = 10'(TREE_DEPTH);
    localparam logic [8:0]      LastDepth = 9'(MAX_DEPTH - 1);
    localparam int unsigned     TmoW      = $clog2(MEM_TIMEOUT + 1);
    localparam logic [TmoW-1:0] LastTmo   = TmoW'(MEM_TIMEOUT - 1);

    localparam logic [1:0] ErrNone    = 2'd0;
    localparam logic [1:0] ErrTimeout = 2'd1;
    localparam logic [1:0] ErrDepth   = 2'd2;
    localparam logic [1:0] ErrBadNode = 2'd3;

    typedef enum logic [1:0] {StIdle, StFetch, StWait, StDone} state_e;

    state_e          state;
    logic [63:0]     feat0_q;
    logic [63:0]     feat1_q;
    logic [63:0]     feat2_q;
    logic [8:0]      depth;
    logic [TmoW-1:0] tmo;

    logic [63:0] sel;
    logic        go_left;
    logic [8:0]  next_addr;
    logic        next_bad;
    logic        finish;
    logic        advance;
    logic [1:0]  fin_err;
    logic [1:0]  fin_pred;

    // Node evaluation for the WAIT state.
    always_comb begin
        case (mem_feature_idx)
            2'd0:    sel = feat0_q;
            2'd1:    sel = feat1_q;
            default: sel = feat2_q;
        endcase

`ifdef TREE_CTRL_SIGNED_CMP_EN
        go_left = ($signed(sel) <= $signed(mem_threshold));
`else
        go_left = (sel <= mem_threshold);
`endif

        next_addr = go_left ? mem_left : mem_right;
        next_bad  = ({1'b0, next_addr} >= AddrLimit);

        finish   = 1'b0;
        advance  = 1'b0;
        fin_err  = ErrNone;
        fin_pred = 2'd0;
        if (!mem_data_valid) begin
            if (tmo == LastTmo) begin
                finish  = 1'b1;
                fin_err = ErrTimeout;
            end
        end else if (mem_is_leaf) begin
            finish   = 1'b1;
            fin_pred = mem_pred;
        end else if (mem_feature_idx == 2'd3 || next_bad) begin
            finish  = 1'b1;
            fin_err = ErrBadNode;
        end else if (depth == LastDepth) begin
            finish  = 1'b1;
            fin_err = ErrDepth;
        end else begin
            advance = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= StIdle;
            ready        <= 1'b1;
            mem_rd_en    <= 1'b0;
            mem_addr     <= RootAddr;
            result_valid <= 1'b0;
            result_pred  <= 2'd0;
            result_depth <= 9'd0;
            err_code     <= ErrNone;
            feat0_q      <= 64'd0;
            feat1_q      <= 64'd0;
            feat2_q      <= 64'd0;
            depth        <= 9'd0;
            tmo          <= '0;
        end else begin
            case (state)
                StIdle: begin
                    if (start) begin
                        feat0_q   <= feat0;
                        feat1_q   <= feat1;
                        feat2_q   <= feat2;
                        mem_addr  <= RootAddr;
                        depth     <= 9'd0;
                        ready     <= 1'b0;
                        mem_rd_en <= 1'b1;
                        state     <= StFetch;
                    end
                end
                StFetch: begin
                    mem_rd_en <= 1'b0;
                    tmo       <= '0;
                    state     <= StWait;
                end
                StWait: begin
                    if (finish) begin
                        result_pred  <= fin_pred;
                        result_depth <= depth;
                        err_code     <= fin_err;
                        state        <= StDone;
                    end else if (advance) begin
                        mem_addr  <= next_addr;
                        depth     <= depth + 9'd1;
                        mem_rd_en <= 1'b1;
                        state     <= StFetch;
                    end else begin
                        tmo <= tmo + TmoW'(1);
                    end
                end
                StDone: begin
                    // Result fields settle in the first DONE cycle; valid is raised one cycle later.
                    if (!result_valid) begin
                        result_valid <= 1'b1;
                    end else if (result_ready) begin
                        result_valid <= 1'b0;
                        ready        <= 1'b1;
                        state        <= StIdle;
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end

endmodule
